// File: rtl/bus_request.sv
// Byte-stream command parser for the PET-bus request path: turns MCU command
// bytes into single read/write transactions handed to sync, returns read bytes.
module bus_request #(
    parameter int ADDR_WIDTH = 17,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  tx_valid,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  pending,
    input  logic                  done,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  we,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  busy,
    output logic                  overrun
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR_HI,
        ADDR_LO,
        DATA,
        REQUEST,
        WAIT_IDLE
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic                    r_tx_valid;
    logic [DATA_WIDTH-1:0]   r_tx_data;
    logic                    r_pending;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wr_data;
    logic                    r_we;
    logic                    r_busy;
    logic                    r_overrun;
    logic                    w_complete;
    logic                    w_unused;

    // cmd[5:1] carry no meaning in the protocol
    assign w_unused   = &{1'b0, rx_data[5:1]};
    assign w_complete = (r_state == REQUEST) && r_pending && done;

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (rx_valid) begin
                    case (rx_data[7:6])
                        2'b11, 2'b10: w_next = ADDR_HI;
                        2'b00:        w_next = DATA;
                        default:      w_next = REQUEST;
                    endcase
                end
            end
            ADDR_HI:   if (rx_valid) w_next = ADDR_LO;
            ADDR_LO:   if (rx_valid) w_next = r_we ? DATA : REQUEST;
            DATA:      if (rx_valid) w_next = REQUEST;
            REQUEST:   if (w_complete) w_next = WAIT_IDLE;
            WAIT_IDLE: if (!done) w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_valid <= 1'b0;
            r_tx_data  <= '0;
            r_pending  <= 1'b0;
            r_addr     <= '0;
            r_wr_data  <= '0;
            r_we       <= 1'b0;
            r_busy     <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_tx_valid <= 1'b0;
            r_busy     <= (w_next != IDLE);
            case (r_state)
                IDLE: begin
                    if (rx_valid) begin
                        r_we <= ~rx_data[6];
                        if (rx_data[7]) r_addr[16] <= rx_data[0];
                    end
                end
                ADDR_HI: if (rx_valid) r_addr[15:8] <= rx_data;
                ADDR_LO: if (rx_valid) r_addr[7:0]  <= rx_data;
                DATA:    if (rx_valid) r_wr_data    <= rx_data;
                REQUEST: begin
                    if (rx_valid) r_overrun <= 1'b1;
                    // A done still high from a previous transaction holds off the request
                    if (!r_pending) begin
                        r_pending <= ~done;
                    end else if (done) begin
                        r_pending <= 1'b0;
                        r_addr    <= r_addr + 1'b1;
                        if (!r_we) begin
                            r_tx_data  <= rd_data;
                            r_tx_valid <= 1'b1;
                        end
                    end
                end
                WAIT_IDLE: if (rx_valid) r_overrun <= 1'b1;
                default: ;
            endcase
        end
    end

    assign tx_valid = r_tx_valid;
    assign tx_data  = r_tx_data;
    assign pending  = r_pending;
    assign addr     = r_addr;
    assign wr_data  = r_wr_data;
    assign we       = r_we;
    assign busy     = r_busy;
    assign overrun  = r_overrun;

endmodule

// File: tb/tb_bus_request.sv
// Directed bench for bus_request: transaction-level reference model compared
// every cycle, plus hand-computed spot checks of the protocol scenarios.
module tb_bus_request;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        pending;
    logic        done;
    logic [16:0] addr;
    logic [7:0]  wr_data;
    logic        we;
    logic [7:0]  rd_data;
    logic        busy;
    logic        overrun;

    int n_pass  = 0;
    int n_total = 0;

    bus_request #(.ADDR_WIDTH(17), .DATA_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_valid(tx_valid), .tx_data(tx_data), .pending(pending), .done(done),
        .addr(addr), .wr_data(wr_data), .we(we), .rd_data(rd_data),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: operands still owed by the current command are a queue
    // of tags (1 = addr hi, 2 = addr lo, 3 = data); a transaction is then a
    // request phase followed by a wait-for-done-low phase.
    int          m_ops[$];
    logic        m_req, m_wait, m_pend, m_we, m_txv, m_ovr, m_busy;
    logic [16:0] m_addr;
    logic [7:0]  m_wr, m_txd;

    task automatic model_step();
        int tag;
        if (reset) begin
            m_ops.delete();
            m_req = 0; m_wait = 0; m_pend = 0; m_we = 0; m_txv = 0; m_ovr = 0;
            m_addr = '0; m_wr = '0; m_txd = '0;
        end else begin
            m_txv = 0;
            if (m_wait) begin
                if (rx_valid) m_ovr = 1;
                if (!done) m_wait = 0;
            end else if (m_req) begin
                if (rx_valid) m_ovr = 1;
                if (m_pend && done) begin
                    m_pend = 0;
                    m_addr = m_addr + 17'd1;
                    if (!m_we) begin m_txv = 1; m_txd = rd_data; end
                    m_req = 0; m_wait = 1;
                end else if (!m_pend) begin
                    m_pend = !done;
                end
            end else if (rx_valid) begin
                if (m_ops.size() == 0) begin
                    m_we = !rx_data[6];
                    if (rx_data[7]) begin
                        m_addr[16] = rx_data[0];
                        m_ops.push_back(1);
                        m_ops.push_back(2);
                    end
                    if (m_we) m_ops.push_back(3);
                end else begin
                    tag = m_ops.pop_front();
                    if (tag == 1)      m_addr[15:8] = rx_data;
                    else if (tag == 2) m_addr[7:0]  = rx_data;
                    else               m_wr         = rx_data;
                end
                if (m_ops.size() == 0) m_req = 1;
            end
        end
        m_busy = (m_ops.size() != 0) || m_req || m_wait;
    endtask

    always @(posedge clk) begin
        model_step();
        #1;
        chk("cyc_pending",  {31'b0, pending},  {31'b0, m_pend});
        chk("cyc_tx_valid", {31'b0, tx_valid}, {31'b0, m_txv});
        chk("cyc_tx_data",  {24'b0, tx_data},  {24'b0, m_txd});
        chk("cyc_addr",     {15'b0, addr},     {15'b0, m_addr});
        chk("cyc_wr_data",  {24'b0, wr_data},  {24'b0, m_wr});
        chk("cyc_we",       {31'b0, we},       {31'b0, m_we});
        chk("cyc_busy",     {31'b0, busy},     {31'b0, m_busy});
        chk("cyc_overrun",  {31'b0, overrun},  {31'b0, m_ovr});
    end

    // Called at a negedge; the byte is consumed at the following posedge.
    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic finish_txn(input logic [7:0] rd, input logic exp_tx, input logic [16:0] exp_addr);
        done    = 1'b1;
        rd_data = rd;
        @(negedge clk);
        done = 1'b0;
        chk("done_pending", {31'b0, pending}, 32'd0);
        chk("done_txv", {31'b0, tx_valid}, {31'b0, exp_tx});
        if (exp_tx) chk("done_txd", {24'b0, tx_data}, {24'b0, rd});
        chk("done_addr", {15'b0, addr}, {15'b0, exp_addr});
        @(negedge clk);
        chk("after_txv", {31'b0, tx_valid}, 32'd0);
        chk("after_busy", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; rx_valid = 1'b0; rx_data = '0; done = 1'b0; rd_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_pending", {31'b0, pending}, 32'd0);
        chk("rst_txv",     {31'b0, tx_valid}, 32'd0);
        chk("rst_overrun", {31'b0, overrun}, 32'd0);
        chk("rst_busy",    {31'b0, busy}, 32'd0);
        chk("rst_addr",    {15'b0, addr}, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // write with address
        send(8'h81); send(8'h80); send(8'h00); send(8'h5A);
        chk("wr_entry_pending", {31'b0, pending}, 32'd0);
        @(negedge clk);
        chk("wr_pending", {31'b0, pending}, 32'd1);
        chk("wr_addr", {15'b0, addr}, 32'h18000);
        chk("wr_data", {24'b0, wr_data}, 32'h5A);
        chk("wr_we", {31'b0, we}, 32'd1);
        finish_txn(8'h00, 1'b0, 17'h18001);

        // read with address, then read-next
        send(8'hC0); send(8'hE8); send(8'h10);
        @(negedge clk);
        chk("rd_addr", {15'b0, addr}, 32'h0E810);
        chk("rd_we", {31'b0, we}, 32'd0);
        finish_txn(8'h42, 1'b1, 17'h0E811);
        send(8'h40);
        @(negedge clk);
        chk("rdn_pending", {31'b0, pending}, 32'd1);
        chk("rdn_addr", {15'b0, addr}, 32'h0E811);
        finish_txn(8'h17, 1'b1, 17'h0E812);

        // address wrap
        send(8'h81); send(8'hFF); send(8'hFF); send(8'h01);
        @(negedge clk);
        chk("wrap_addr_pre", {15'b0, addr}, 32'h1FFFF);
        finish_txn(8'h00, 1'b0, 17'h00000);
        send(8'h00); send(8'h02);
        @(negedge clk);
        chk("wrn_pending", {31'b0, pending}, 32'd1);
        chk("wrn_addr", {15'b0, addr}, 32'h00000);
        chk("wrn_data", {24'b0, wr_data}, 32'h02);
        finish_txn(8'h00, 1'b0, 17'h00001);

        // stale done holds off the request
        done = 1'b1;
        send(8'h40);
        repeat (3) begin
            @(negedge clk);
            chk("stale_pending_low", {31'b0, pending}, 32'd0);
        end
        done = 1'b0;
        @(negedge clk);
        chk("stale_pending_high", {31'b0, pending}, 32'd1);
        chk("stale_addr", {15'b0, addr}, 32'h00001);

        // held done after completion
        done = 1'b1; rd_data = 8'h33;
        @(negedge clk);
        chk("held_txv", {31'b0, tx_valid}, 32'd1);
        chk("held_txd", {24'b0, tx_data}, 32'h33);
        repeat (3) begin
            @(negedge clk);
            chk("held_busy", {31'b0, busy}, 32'd1);
            chk("held_pending", {31'b0, pending}, 32'd0);
            chk("held_txv_once", {31'b0, tx_valid}, 32'd0);
        end
        done = 1'b0;
        @(negedge clk);
        chk("held_idle", {31'b0, busy}, 32'd0);

        // overrun during pending, then byte coincident with done
        send(8'h40);
        @(negedge clk);
        send(8'h99);
        chk("ovr_set", {31'b0, overrun}, 32'd1);
        chk("ovr_addr", {15'b0, addr}, 32'h00002);
        chk("ovr_pending", {31'b0, pending}, 32'd1);
        rx_valid = 1'b1; rx_data = 8'h55; done = 1'b1; rd_data = 8'hAB;
        @(negedge clk);
        rx_valid = 1'b0; done = 1'b0;
        chk("coin_txv", {31'b0, tx_valid}, 32'd1);
        chk("coin_txd", {24'b0, tx_data}, 32'hAB);
        chk("coin_addr", {15'b0, addr}, 32'h00003);
        @(negedge clk);

        // reset mid-transaction
        send(8'h00); send(8'h77);
        @(negedge clk);
        chk("mid_pending", {31'b0, pending}, 32'd1);
        chk("mid_wr", {24'b0, wr_data}, 32'h77);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_pending", {31'b0, pending}, 32'd0);
        chk("mid_rst_overrun", {31'b0, overrun}, 32'd0);
        chk("mid_rst_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        send(8'h40);
        @(negedge clk);
        chk("recover_pending", {31'b0, pending}, 32'd1);
        chk("recover_addr", {15'b0, addr}, 32'h00000);
        finish_txn(8'h5C, 1'b1, 17'h00001);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bus_request.md
Name: bus_request

Overview:
- Upstream stage of the bus `sync` block; this block feeds `sync`'s `pending` input.
- Parses a byte stream of MCU commands, arriving from the SPI receiver, into single PET-bus read/write transactions.
- For each transaction it holds `pending` with a stable address, data and direction until `sync` reports `done`.
- It captures read data and returns it to the SPI transmitter as a one-cycle `tx_valid` pulse.

Parameters:
- ADDR_WIDTH, 17, width of the bus address (A16 is carried in command bit 0).
- DATA_WIDTH, 8, width of the bus data. Fixed at 8 for the byte protocol; other values are unsupported.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- rx_valid  input  1  one-cycle pulse: rx_data holds a received byte.
- rx_data  input  8  received command/operand byte.
- tx_valid  output  1  one-cycle pulse: tx_data holds read result.
- tx_data  output  8  read result byte.
- pending  output  1  transaction request to sync.
- done  input  1  from sync; transaction complete, rd_data valid.
- addr  output  ADDR_WIDTH  transaction address.
- wr_data  output  8  write data.
- we  output  1  1 = write, 0 = read.
- rd_data  input  8  bus read data, valid while done = 1.
- busy  output  1  high whenever state is not IDLE.
- overrun  output  1  sticky: a byte was received while in REQUEST or WAIT_IDLE.

Behaviour:
- Reset: all of the following are 0, and state = IDLE:
  - pending, we, tx_valid, overrun
  - addr, wr_data, tx_data
- Command byte cmd[7:6] encoding:
  - 2'b11 RD_AT: then bytes A15..8, A7..0; read.
  - 2'b10 WR_AT: then A15..8, A7..0, data; write.
  - 2'b01 RD_NEXT: no operands; read at the current addr.
  - 2'b00 WR_NEXT: then data; write at the current addr.
  - cmd[0] is A16, used only by the *_AT commands.
  - cmd[5:1] are ignored.
- States: IDLE, ADDR_HI, ADDR_LO, DATA, REQUEST, WAIT_IDLE.
- IDLE, on rx_valid:
  - Latch the command into an internal register; set we = ~cmd[6].
  - *_AT: load addr[16] = cmd[0], go to ADDR_HI.
  - WR_NEXT: go to DATA.
  - RD_NEXT: go to REQUEST.
- ADDR_HI, on rx_valid: load addr[15:8], go to ADDR_LO.
- ADDR_LO, on rx_valid: load addr[7:0]; go to DATA if the command is a write, else REQUEST.
- DATA, on rx_valid: load wr_data, go to REQUEST.
- Bytes are consumed only on rx_valid; states wait indefinitely otherwise. There is no timeout.
- REQUEST:
  - Entry: pending is 0 in the entry cycle and is registered high from the following edge.
  - If done is already 1 on entry (stale), pending stays 0 until done has been sampled 0 for one edge.
  - While pending = 1: addr, wr_data and we are frozen.
  - On the edge where pending = 1 and done = 1:
    - pending <= 0
    - addr <= addr + 1 (modulo 2^ADDR_WIDTH; 0x1FFFF wraps to 0x00000)
    - If read: tx_data <= rd_data and tx_valid <= 1 for exactly one cycle.
    - State goes to WAIT_IDLE.
- WAIT_IDLE: return to IDLE on the first edge where done = 0. This prevents a held done from completing the next request.
- Latency:
  - Last command byte to pending high: 2 edges (state register edge, then pending register edge).
  - done sampled high to tx_valid high: 1 edge.
- rx_valid in REQUEST or WAIT_IDLE: the byte is discarded and overrun <= 1. overrun stays set until reset.
- rx_valid coincident with the done edge: the byte is discarded (overrun set); the transaction still completes normally.
- Reset mid-transaction: pending drops on the reset edge; the parser state is lost. Recovery must come from the next command.
- busy = (state != IDLE), registered.

Test Plan:
- Reset then idle: reset = 1 for 2 cycles -> pending, tx_valid, overrun, busy all 0; addr = 0x00000.
- Write with address: bytes 0x81, 0x80, 0x00, 0x5A -> pending high 2 edges after the last byte, addr = 0x18000, wr_data = 0x5A, we = 1. Assert done -> pending low next edge, addr = 0x18001, no tx_valid.
- Read and next-read: RD_AT 0xC0, 0xE8, 0x10 with rd_data = 0x42 on done -> one-cycle tx_valid, tx_data = 0x42. Then RD_NEXT 0x40 -> addr = 0x0E811.
- Wrap-around: WR_AT 0x81, 0xFF, 0xFF, data 0x01, done -> addr = 0x00000. WR_NEXT 0x00, 0x02 -> write issued at 0x00000.
- Stale done and held done:
  - done held 1 while the request is issued -> pending stays 0 until done falls, then rises.
  - done held 3 cycles after completion -> state stays in WAIT_IDLE and no second request is issued.
- Overrun and reset: rx_valid during pending -> overrun = 1, byte ignored, addr/wr_data unchanged. Reset asserted while pending = 1 -> pending = 0 and overrun = 0 on that edge.
